hex_display_ctrl: RTL
=====================

Name: hex_display_ctrl

Overview:
Loads a packed multi-digit hex value through a valid/ready handshake and sequences one shared hex_to_7seg decoder across all digits. A prescaled scan writes one digit per slot into per-digit registered segment outputs. Optional leading-zero blanking is applied. Sits between the lab datapath (counters, ALU results) and the HEX display pins.

Parameters:
NDIG, 4, number of 7-segment digits driven (1..8)
SCAN_DIV, 50000, clk cycles per digit slot (>=1); use 4 in simulation

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  new value offered
load_ready  output  1  controller can accept (= !busy)
value  input  4*NDIG  packed hex digits, digit k = value[4k+3:4k], digit 0 least significant
blank_lz  input  1  enable leading-zero blanking, sampled at accept
busy  output  1  update pass in progress
done  output  1  one-cycle pulse when the last digit is written
seg_out  output  7*NDIG  active-low segments, digit k = seg_out[7k+6:7k]

Behaviour:
- Reset (async assert, sync release): seg_out all 1 (every digit blank, SEG_BLANK = 7'h7F), busy=0, done=0, load_ready=1, state IDLE, digit index 0, prescaler 0.
- States: IDLE and UPDATE.
- IDLE -> UPDATE on the edge where load_valid && load_ready (accept edge T). At that edge:
  - capture value into val_q and blank_lz into lz_q;
  - clear prescaler and digit index;
  - busy=1.
- UPDATE:
  - prescaler counts 0..SCAN_DIV-1; tick when the count reaches SCAN_DIV-1.
  - On each tick, write seg_reg[idx] from the shared decoder output, whose input is nibble idx of val_q, then increment idx.
  - Digit k is written at edge T+(k+1)*SCAN_DIV.
- Completion:
  - On the tick that writes digit NDIG-1: done=1 for one cycle, busy=0 at the same edge, return to IDLE.
  - Total busy time is NDIG*SCAN_DIV cycles.
- Leading-zero blanking: if lz_q=1, every digit above the highest nonzero nibble is written as SEG_BLANK. Digit 0 is never blanked, so a value of 0 shows "0".
- Only one decoder instance exists. Digit selection is a mux driven by idx; there are no per-digit decoders.
- load_valid while busy is ignored, and the value is not queued. The requester must hold load_valid until load_ready.
- Undisplayed digits keep their previous segment value until rewritten, so the display never flickers mid-update.
- Changes to value or blank_lz after the accept edge have no effect on the current pass.
- Reset mid-UPDATE immediately blanks all digits and aborts the pass. No done pulse is generated.
- idx width is clog2(NDIG), with minimum 1. idx never exceeds NDIG-1.

Optional Feature:
Macro: HEX_DISPLAY_CTRL_BLINK_EN
- With macro:
  - adds input blink (1 bit) and a free-running blink counter, period 8*NDIG*SCAN_DIV cycles (reset 0);
  - phase flop toggles at each counter wrap;
  - when blink=1 and phase=1, seg_out is forced to all 1. Internal seg_reg values are untouched.
  - blink=0 gives normal output.
- Without macro: no blink port and no blink counter. seg_out equals seg_reg directly.

Decomposition:
- Package hex_display_pkg holds:
  - SEG_BLANK = 7'h7F;
  - state enum IDLE=1'b0, UPDATE=1'b1;
  - the digit slice width constants NIB_W=4 and SEG_W=7.
- One natural sub-module, hex_scan_prescaler: counter with a clear input that emits the tick output every SCAN_DIV cycles.
- The existing hex_to_7seg is instantiated once as the shared decoder.

Test Plan:
- (NDIG=4, SCAN_DIV=4) Reset, then load 16'h1A3F with blank_lz=0:
  - busy high for 16 cycles; done pulses at T+16;
  - seg_out digit0=0001110, d1=0110000, d2=0001000, d3=1111001;
  - digit k changes at exactly T+4(k+1).
- Load 16'h00C5 with blank_lz=1: d3=d2=1111111, d1=1000110, d0=0010010.
- Load 16'h0000 with blank_lz=1: d3..d1=1111111, d0=1000000. With blank_lz=0, all four digits are 1000000.
- Assert load_valid with 16'h7777 at T+5 during a pass for 16'h1234:
  - load_ready=0 and the request is ignored;
  - final display is 1234;
  - a held request is accepted the cycle after done.
- Pull rst_n low at T+9 mid-pass: seg_out immediately all 1, busy=0, no done pulse; a fresh load afterwards completes normally.
- (BLINK_EN) blink=1 after showing 16'h1A3F: seg_out alternates between all-1 and the decoded value every 128 cycles, and seg_reg is unchanged.

Source files
------------

// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared constants and state encoding for the hex display controller
package hex_display_pkg;
  localparam int NIB_W = 4;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  typedef enum logic {IDLE = 1'b0, UPDATE = 1'b1} state_t;
endpackage

// File: rtl/hex_scan_prescaler.sv
// hex_scan_prescaler: clearable slot counter emitting tick on every SCAN_DIV-th enabled cycle
module hex_scan_prescaler #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(SCAN_DIV - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: active-low gfedcba segment decoder for one hex nibble
module hex_to_7seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end
endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: scanned multi-digit hex display loader, one shared decoder (optional blink via HEX_DISPLAY_CTRL_BLINK_EN)
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef HEX_DISPLAY_CTRL_BLINK_EN
  input  logic                  blink,
`endif
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [NIB_W*NDIG-1:0] value,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic [SEG_W*NDIG-1:0] seg_out
);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [NIB_W*NDIG-1:0] val_q;
  logic lz_q;
  logic [NDIG-1:0][SEG_W-1:0] seg_reg;
  logic tick, accept, last, lead_zero;
  logic [NIB_W-1:0] nib;
  logic [SEG_W-1:0] dec_seg, wr_seg;
  assign busy = state == UPDATE;
  assign load_ready = !busy;
  assign accept = load_valid && load_ready;
  assign last = tick && idx == IW'(NDIG - 1);
  assign nib = val_q[int'(idx)*NIB_W +: NIB_W];
  assign lead_zero = lz_q && idx != '0 && (val_q >> (NIB_W * int'(idx))) == '0;
  assign wr_seg = lead_zero ? SEG_BLANK : dec_seg;
  hex_scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (busy),
    .tick (tick)
  );
  hex_to_7seg u_dec (
    .nib(nib),
    .seg(dec_seg)
  );
  always_comb begin
    state_nx = state;
    state_nx = accept ? UPDATE : last ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      val_q   <= '0;
      lz_q    <= 1'b0;
      seg_reg <= {NDIG{SEG_BLANK}};
      done    <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        val_q <= value;
        lz_q  <= blank_lz;
        idx   <= '0;
      end
      if (tick) begin
        seg_reg[idx] <= wr_seg;
        idx          <= last ? '0 : idx + 1'b1;
      end
    end
  end
`ifdef HEX_DISPLAY_CTRL_BLINK_EN
  localparam int BP = 8 * NDIG * SCAN_DIV;
  localparam int BW = $clog2(BP);
  logic [BW-1:0] bcnt;
  logic phase, bwrap;
  assign bwrap = bcnt == BW'(BP - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else begin
      bcnt  <= bwrap ? '0 : bcnt + 1'b1;
      phase <= phase ^ bwrap;
    end
  end
  assign seg_out = (blink && phase) ? '1 : seg_reg;
`else
  assign seg_out = seg_reg;
`endif
endmodule
